// File: rtl/precision_ctl_pipe_pkg.sv
// Shared types and elaboration-time helpers for the precision controller pipeline.
package precision_ctl_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_ADAPT    = 2'b00,
    MODE_FULL     = 2'b01,
    MODE_MIN      = 2'b10,
    MODE_FULL_ALT = 2'b11
  } mode_e;

  function automatic int bw_width(input int man_w);
    return $clog2(man_w + 1);
  endfunction

  function automatic int exp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Low half of the table narrows with index, high half widens again.
  function automatic int default_bw(input int idx, input int man_w, input int min_bw);
    int v;
    if (idx < 8) v = man_w - idx;
    else         v = min_bw + idx - 8;
    if (v < min_bw) v = min_bw;
    if (v > man_w)  v = man_w;
    return v;
  endfunction

endpackage

// File: rtl/precision_ctl_pipe_table.sv
// 16-entry bit-width register file: clamped writes, asynchronous read, reset to defaults.
module precision_bw_table
  import precision_ctl_pipe_pkg::*;
#(
  parameter int MAN_W  = 11,
  parameter int MIN_BW = 4,
  localparam int BW_W  = bw_width(MAN_W)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [3:0]      waddr,
  input  logic [BW_W-1:0] wdata,
  input  logic [3:0]      raddr,
  output logic [BW_W-1:0] rdata
);

  logic [BW_W-1:0] mem_q [16];
  logic [BW_W-1:0] mem_d [16];
  logic [BW_W-1:0] wclamped;

  always_comb begin
    if (wdata < BW_W'(MIN_BW))     wclamped = BW_W'(MIN_BW);
    else if (wdata > BW_W'(MAN_W)) wclamped = BW_W'(MAN_W);
    else                           wclamped = wdata;
    mem_d = mem_q;
    if (we) mem_d[waddr] = wclamped;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 16; i++)
        mem_q[i] <= BW_W'(default_bw(int'(i), MAN_W, MIN_BW));
    end else begin
      mem_q <= mem_d;
    end
  end

  // Reads see the registered contents, so a same-cycle write is not yet visible.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/precision_ctl_pipe.sv
// Two-stage precision controller: exponent sum in S1, regime lookup and mask in S2.
module precision_ctl_pipe
  import precision_ctl_pipe_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 11,
  parameter int MIN_BW = 4,
  parameter int RG_LSB = 4,
  parameter int CNT_W  = 16,
  localparam int BW_W  = bw_width(MAN_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] in_expa,
  input  logic [EXP_W-1:0] in_expb,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAN_W-1:0] out_mask,
  output logic [BW_W-1:0]  out_bw,
  output logic [3:0]       out_rg,
  output logic             out_special,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_addr,
  input  logic [BW_W-1:0]  cfg_data,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] red_cnt
);

  localparam int SUM_W = EXP_W + 2;
  localparam int EXT_W = SUM_W + RG_LSB + 4;
  localparam logic [EXP_W:0] BIAS = (EXP_W + 1)'(exp_bias(EXP_W));
  localparam logic [MAN_W-1:0] ONES = '1;

  logic                    s1_valid_q, s1_valid_d;
  logic signed [SUM_W-1:0] s1_sum_q, s1_sum_d;
  logic                    s1_special_q, s1_special_d;
  mode_e                   s1_mode_q, s1_mode_d;

  logic             out_valid_q, out_valid_d;
  logic [MAN_W-1:0] out_mask_q, out_mask_d;
  logic [BW_W-1:0]  out_bw_q, out_bw_d;
  logic [3:0]       out_rg_q, out_rg_d;
  logic             out_special_q, out_special_d;
  logic [CNT_W-1:0] red_cnt_q, red_cnt_d;

  logic              s2_free, accept;
  logic signed [EXP_W:0] ua, ub;
  logic [SUM_W-1:0]  mag;
  logic [EXT_W-1:0]  mag_ext;
  logic [3:0]        rg;
  logic [BW_W-1:0]   tbl_bw, bw_sel;

  assign s2_free  = !out_valid_q || out_ready;
  assign in_ready = rst_n && (!s1_valid_q || s2_free);
  assign accept   = in_valid && in_ready;

  always_comb begin
    ua = $signed({1'b0, in_expa} - BIAS);
    ub = $signed({1'b0, in_expb} - BIAS);
    s1_sum_d     = s1_sum_q;
    s1_special_d = s1_special_q;
    s1_mode_d    = s1_mode_q;
    s1_valid_d   = s2_free ? 1'b0 : s1_valid_q;
    if (accept) begin
      s1_valid_d   = 1'b1;
      s1_sum_d     = $signed({ua[EXP_W], ua}) + $signed({ub[EXP_W], ub});
      s1_special_d = (in_expa == '0) || (in_expa == '1) || (in_expb == '0) || (in_expb == '1);
      s1_mode_d    = mode_e'(in_mode);
    end
  end

  // Zero-extend the magnitude so a regime field reaching past its top reads as 0.
  always_comb begin
    mag     = s1_sum_q[SUM_W-1] ? SUM_W'(-s1_sum_q) : SUM_W'(s1_sum_q);
    mag_ext = EXT_W'(mag);
    rg      = mag_ext[RG_LSB +: 4];
  end

  precision_bw_table #(
    .MAN_W  (MAN_W),
    .MIN_BW (MIN_BW)
  ) u_table (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (rg),
    .rdata (tbl_bw)
  );

  always_comb begin
    if (s1_special_q) begin
      bw_sel = BW_W'(MAN_W);
    end else begin
      case (s1_mode_q)
        MODE_ADAPT: bw_sel = tbl_bw;
        MODE_MIN:   bw_sel = BW_W'(MIN_BW);
        default:    bw_sel = BW_W'(MAN_W);
      endcase
    end
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_mask_d    = out_mask_q;
    out_bw_d      = out_bw_q;
    out_rg_d      = out_rg_q;
    out_special_d = out_special_q;
    if (s2_free) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_mask_d    = ~(ONES >> bw_sel);
        out_bw_d      = bw_sel;
        out_rg_d      = rg;
        out_special_d = s1_special_q;
      end
    end
    red_cnt_d = red_cnt_q;
    if (cnt_clr)
      red_cnt_d = '0;
    else if (out_valid_q && out_ready && (out_bw_q < BW_W'(MAN_W)) && (red_cnt_q != '1))
      red_cnt_d = red_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_sum_q      <= '0;
      s1_special_q  <= 1'b0;
      s1_mode_q     <= MODE_ADAPT;
      out_valid_q   <= 1'b0;
      out_mask_q    <= '0;
      out_bw_q      <= '0;
      out_rg_q      <= '0;
      out_special_q <= 1'b0;
      red_cnt_q     <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_sum_q      <= s1_sum_d;
      s1_special_q  <= s1_special_d;
      s1_mode_q     <= s1_mode_d;
      out_valid_q   <= out_valid_d;
      out_mask_q    <= out_mask_d;
      out_bw_q      <= out_bw_d;
      out_rg_q      <= out_rg_d;
      out_special_q <= out_special_d;
      red_cnt_q     <= red_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_mask    = out_mask_q;
  assign out_bw      = out_bw_q;
  assign out_rg      = out_rg_q;
  assign out_special = out_special_q;
  assign red_cnt     = red_cnt_q;

endmodule

// File: doc/precision_ctl_pipe.md
# precision_ctl_pipe

Pipelined, parametrised successor to the combinational precision controller. It takes a pair of operand exponents with a valid/ready handshake and forms the unbiased product exponent. The regime field of its magnitude indexes a runtime-programmable 16-entry bit-width table, and the block returns an MSB-aligned mantissa precision mask two cycles later. It sits between the operand-fetch stage and the variable-precision multiplier datapath. It also keeps a saturating count of reduced-precision products.

## Interface
Parameters:
- EXP_W, 8, exponent width; bias = 2^(EXP_W-1)-1
- MAN_W, 11, mask width (mantissa incl. hidden bit)
- MIN_BW, 4, lowest permitted bit-width; 1 <= MIN_BW <= MAN_W
- RG_LSB, 4, LSB position of the 4-bit regime field within the exponent magnitude
- CNT_W, 16, reduced-precision counter width

Ports (BW_W = clog2(MAN_W+1)):
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept this cycle
- in_expa, in_expb  in  EXP_W  biased exponents
- in_mode  in  2  00 adaptive, 01 force full, 10 force min, 11 treated as 01
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_mask  out  MAN_W  precision mask, top out_bw bits set
- out_bw  out  BW_W  selected bit-width
- out_rg  out  4  regime index used
- out_special  out  1  an operand exponent was all-zeros or all-ones
- cfg_we  in  1  table write strobe
- cfg_addr  in  4  table entry
- cfg_data  in  BW_W  bit-width to store
- cnt_clr  in  1  clear reduced-precision counter
- red_cnt  out  CNT_W  count of accepted outputs with out_bw < MAN_W

## Operation
- Transfer occurs on valid && ready at either port. in_mode travels with its transaction.
- S1 (on input accept) registers the following:
  - ua = {0,expa} - bias and ub likewise, each EXP_W+1 signed.
  - sum = ua + ub, EXP_W+2 signed.
  - special = either exponent all-zeros or all-ones.
- S2 computes the result fields:
  - mag = |sum|.
  - rg = mag[RG_LSB+3:RG_LSB]. Bits above the field are ignored; positions beyond the mag width read as 0.
  - bw = table[rg] for adaptive mode.
- Overrides and mask:
  - bw = MAN_W if special, or if the mode is force full.
  - bw = MIN_BW if the mode is force min.
  - mask = MSB-first ones of length bw, zeros below.
- Table reset contents: entry i<8 holds max(MAN_W-i, MIN_BW); entry i>=8 holds min(MIN_BW+i-8, MAN_W). For the defaults this gives 11,10,9,8,7,6,5,4,4,5,6,7,8,9,10,11.
- Table writes store cfg_data clamped to [MIN_BW, MAN_W]. A write is visible to S2 lookups from the next cycle. A lookup of the same entry in the write cycle sees the old value.
- red_cnt:
  - Increments on each output transfer with bw < MAN_W and saturates at all-ones.
  - cnt_clr has priority over an increment in the same cycle; the result is 0.

## Timing
- Latency: 2 cycles from input transfer to out_valid, with no stall.
- Throughput: 1 transaction per cycle.
- Ready logic:
  - in_ready = rst_n && (!s1_valid || s2_free).
  - s2_free = !out_valid || out_ready.
  - in_ready is combinational from out_ready; there is no other comb path in to out.
- Stall: with out_valid && !out_ready, all S2 outputs hold stable. S1 holds when S2 is not free. in_ready drops only when both stages are full.
- Reset (rst_n low at an edge) sets the following:
  - out_valid=0, s1_valid=0, out_mask=0, out_bw=0, out_rg=0, out_special=0, red_cnt=0.
  - The table is restored to its defaults.
  - in-flight transactions are discarded, and in_ready=0 while rst_n is low.
- Mid-stall config writes do not alter an already-computed held S2 result.

## Structure
- Shared package: mode encodings, the BW_W function, the default-table function and the bias function.
- One sub-module, precision_bw_table: 16 x BW_W register file with clamped write, async read and reset to defaults.
- Top level holds the S1/S2 pipeline, the handshake and the counter.

## Test plan
- Centre regime: expa=127, expb=127, mode 00 → after 2 cycles rg=0, bw=11, mask=11111111111, red_cnt unchanged.
- Positive exponent: expa=200, expb=127 (sum 73) → rg=4, bw=7, mask=11111110000, red_cnt +1.
- Negative and high regimes:
  - expa=20, expb=127 (sum -107, mag 107) → rg=6, bw=5, mask=11111000000.
  - expa=254, expb=254 → rg=15, bw=11.
- Special and forced modes:
  - expa=0 → out_special=1, mask all ones.
  - mode 10 with 127/127 → bw=4, mask=11110000000.
- Config write: write addr 4 data 9, then 200/127 → mask=11111111100. Write data 2 → stored 4. A same-cycle write and lookup returns the old entry.
- Backpressure: issue 3 back-to-back inputs with out_ready low for 4 cycles → in_ready low after 2 accepts, outputs held, then all 3 delivered in order. Then check:
  - a rst_n pulse mid-stall clears out_valid and red_cnt;
  - the counter saturates at 0xFFFF.
